am_move_walker: RTL and testbench
=================================

# am_move_walker

Synthesizable sequencer that walks the move list produced by `all_moves` once `am_moves_ready` rises. It drives `am_move_index`, waits a parametrised move-RAM latency, and presents each move as a UCI word on a valid/ready output stream with check status. It then pulses `am_clear_moves` and re-arms. It sits between `all_moves` and any consumer of generated moves, such as a host FIFO, a search-tree feeder or a debug UART.

## Interface
Parameters:
- `MAX_POSITIONS_LOG2`, default 8: width of move count and move index.
- `UCI_WIDTH`, default 16: UCI word width, {promotion[3:0], to[5:0], from[5:0]}.
- `RAM_LATENCY`, default 5: cycles from an index change to valid `uci_in`/`capture_in`/check inputs; legal range 1..15.

Ports (clock and reset first):
- `clk`  in  1  sole clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `enable`  in  1  arms the walker; sampled only in IDLE.
- `am_moves_ready`  in  1  from `all_moves`; the move list is complete.
- `am_move_count`  in  MAX_POSITIONS_LOG2  number of legal moves.
- `initial_mate`, `initial_stalemate`  in  1 each  root terminal flags.
- `uci_in`  in  UCI_WIDTH  move at `am_move_index`.
- `capture_in`, `white_in_check_in`, `black_in_check_in`  in  1 each  per-move flags.
- `am_move_index`  out  MAX_POSITIONS_LOG2  move RAM read index.
- `am_clear_moves`  out  1  one-cycle clear pulse to `all_moves`.
- `out_valid`  out  1  stream valid.
- `out_ready`  in  1  stream ready.
- `out_uci`  out  UCI_WIDTH  registered UCI word.
- `out_index`  out  MAX_POSITIONS_LOG2  index of `out_uci`.
- `out_status`  out  2  0 no check, 1 white in check, 2 black in check; white takes priority.
- `out_last`  out  1  set on the final move of the list.
- `done`  out  1  one-cycle pulse when the list is finished.
- `term`  out  2  status of the last list: 0 moves existed, 1 mate, 2 stalemate, 3 no moves with no flag.
- `emitted`  out  MAX_POSITIONS_LOG2+1  moves emitted for the last list.

## Operation
States: IDLE, INIT, WAIT, EMIT, CLEAR, CLEAR_WAIT.

- IDLE
  - Holds `am_move_index`=0.
  - When `enable && am_moves_ready`: latch `am_move_count` into `cnt`, clear `emitted`, go to INIT.
- INIT
  - If `cnt==0`: set `term` (mate → 1, else stalemate → 2, else 3), go to CLEAR.
  - Else: `term`=0, load the wait counter with RAM_LATENCY−1, go to WAIT.
- WAIT
  - Decrement the wait counter.
  - At 0, with the inputs now valid:
    - If the move is emitted, register `out_uci`, `out_index`, `out_status` and `out_last` = (`am_move_index`+1 == `cnt`), and go to EMIT.
    - If the move is skipped (filter, see Configuration): advance the index, or go to CLEAR if this was the last move.
- EMIT
  - `out_valid`=1. Payload is stable until handshake.
  - On `out_valid && out_ready`: `emitted`++.
  - If `out_last`, go to CLEAR. Else `am_move_index`++, reload the wait counter, go to WAIT.
- CLEAR
  - `am_clear_moves`=1 and `done`=1 for exactly this cycle; go to CLEAR_WAIT.
- CLEAR_WAIT
  - Stay until `am_moves_ready`==0, which takes at least 1 cycle; then go to IDLE.
  - This prevents re-walking a stale list.

Rules:
- Index arithmetic: `am_move_index`+1 is compared at MAX_POSITIONS_LOG2+1 bits, so `cnt` = 2^N−1 terminates without wrap.
- `enable` deasserted mid-walk has no effect; the current list completes.
- `out_ready` may be high before `out_valid`. The handshake only counts in EMIT.

## Timing
- Reset values:
  - State IDLE.
  - `am_move_index`=0, `am_clear_moves`=0, `out_valid`=0.
  - `out_uci`=0, `out_index`=0, `out_status`=0, `out_last`=0.
  - `done`=0, `term`=0, `emitted`=0.
- Reset in any state returns to IDLE next cycle and drops `out_valid` with no handshake.
- Latency:
  - IDLE → first `out_valid` = 2 + RAM_LATENCY cycles.
  - Handshake → next `out_valid` = 1 + RAM_LATENCY cycles.
  - Last handshake → `am_clear_moves` = 1 cycle.
- Throughput with `out_ready` tied high: one move per RAM_LATENCY+1 cycles.
- Empty list: `done` and `am_clear_moves` are asserted 2 cycles after arming.

## Configuration
- `AM_WALKER_CAPTURE_FILTER_EN`
  - Defined: moves with `capture_in`==0 are skipped, with no `out_valid`. `out_last` marks the last emitted move when it is the final list entry. When the final entry is a skipped non-capture, no `out_last` is seen, and the consumer uses `done`. `emitted` counts captures only.
  - Undefined: every move is emitted and `capture_in` is ignored.

## Test plan
- Count=3, `out_ready`=1, RAM_LATENCY=5 → three beats at indices 0,1,2; `out_last` on index 2 only; `emitted`=3; `done`/`am_clear_moves` 1 cycle after the third handshake.
- Count=2, `out_ready` low for 10 cycles in the first EMIT → `out_valid` held, `out_uci`/`out_index` stable, `am_move_index` unchanged; beat 2 follows 1+RAM_LATENCY cycles after the handshake.
- Count=0 with `initial_mate`=1 → no `out_valid`; `term`=1; `done` pulse; `emitted`=0. Repeat with `initial_stalemate` → `term`=2.
- `white_in_check_in` and `black_in_check_in` both high → `out_status`=1. Black only → 2.
- Reset asserted in EMIT of move 1 of 4 → next cycle IDLE, all outputs at reset values. Re-arm → walk restarts at index 0.
- With `AM_WALKER_CAPTURE_FILTER_EN`, count=4, captures at indices 1 and 3 → beats at 1 and 3, `out_last` on 3, `emitted`=2. Without the macro the same list gives 4 beats.

Source files
------------

// File: rtl/am_move_walker_if.sv
// am_move_walker_if: valid/ready stream carrying one generated move as a UCI word with index, check status and last flag.
interface am_move_walker_if #(
  parameter int MAX_POSITIONS_LOG2 = 8,
  parameter int UCI_WIDTH = 16
);
  logic out_valid;
  logic out_ready;
  logic [UCI_WIDTH-1:0] out_uci;
  logic [MAX_POSITIONS_LOG2-1:0] out_index;
  logic [1:0] out_status;
  logic out_last;
  modport master(output out_valid, out_uci, out_index, out_status, out_last, input out_ready);
  modport slave(input out_valid, out_uci, out_index, out_status, out_last, output out_ready);
endinterface

// File: rtl/am_move_walker.sv
// am_move_walker: walks the all_moves list and streams each move; AM_WALKER_CAPTURE_FILTER_EN emits captures only.
module am_move_walker #(
  parameter int MAX_POSITIONS_LOG2 = 8,
  parameter int UCI_WIDTH = 16,
  parameter int RAM_LATENCY = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic am_moves_ready,
  input  logic [MAX_POSITIONS_LOG2-1:0] am_move_count,
  input  logic initial_mate,
  input  logic initial_stalemate,
  input  logic [UCI_WIDTH-1:0] uci_in,
  input  logic capture_in,
  input  logic white_in_check_in,
  input  logic black_in_check_in,
  output logic [MAX_POSITIONS_LOG2-1:0] am_move_index,
  output logic am_clear_moves,
  am_move_walker_if.master stream,
  output logic done,
  output logic [1:0] term,
  output logic [MAX_POSITIONS_LOG2:0] emitted
);
  localparam int N = MAX_POSITIONS_LOG2;
  localparam logic [3:0] LAT = 4'(RAM_LATENCY - 1);
  typedef enum logic [2:0] {IDLE, INIT, WAIT, EMIT, CLEAR, CLEAR_WAIT} state_t;
  state_t state, state_nx;
  logic [N-1:0] cnt;
  logic [3:0] wcnt;
  logic keep, is_last, fire;
`ifdef AM_WALKER_CAPTURE_FILTER_EN
  assign keep = capture_in;
`else
  logic unused_capture;
  assign unused_capture = capture_in;
  assign keep = 1'b1;
`endif
  // compared one bit wider so a full 2^N-1 list ends without the index wrapping
  assign is_last = {1'b0, am_move_index} + (N+1)'(1) == {1'b0, cnt};
  assign fire = stream.out_valid && stream.out_ready;
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = enable && am_moves_ready ? INIT : IDLE;
      INIT: state_nx = cnt == '0 ? CLEAR : WAIT;
      WAIT: state_nx = wcnt != '0 ? WAIT : keep ? EMIT : is_last ? CLEAR : WAIT;
      EMIT: state_nx = !fire ? EMIT : stream.out_last ? CLEAR : WAIT;
      CLEAR: state_nx = CLEAR_WAIT;
      CLEAR_WAIT: state_nx = am_moves_ready ? CLEAR_WAIT : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    stream.out_valid = state == EMIT;
    am_clear_moves = state == CLEAR;
    done = state == CLEAR;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      am_move_index <= '0;
      cnt <= '0;
      wcnt <= '0;
      term <= '0;
      emitted <= '0;
      stream.out_uci <= '0;
      stream.out_index <= '0;
      stream.out_status <= '0;
      stream.out_last <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          am_move_index <= '0;
          if (enable && am_moves_ready) begin
            cnt <= am_move_count;
            emitted <= '0;
          end
        end
        INIT: begin
          term <= cnt != '0 ? 2'd0 : initial_mate ? 2'd1 : initial_stalemate ? 2'd2 : 2'd3;
          wcnt <= LAT;
        end
        WAIT: begin
          if (wcnt != '0) wcnt <= wcnt - 4'd1;
          else if (keep) begin
            stream.out_uci <= uci_in;
            stream.out_index <= am_move_index;
            stream.out_status <= white_in_check_in ? 2'd1 : black_in_check_in ? 2'd2 : 2'd0;
            stream.out_last <= is_last;
          end else if (!is_last) begin
            am_move_index <= am_move_index + N'(1);
            wcnt <= LAT;
          end
        end
        EMIT: begin
          if (fire) begin
            emitted <= emitted + (N+1)'(1);
            if (!stream.out_last) begin
              am_move_index <= am_move_index + N'(1);
              wcnt <= LAT;
            end
          end
        end
        CLEAR: am_move_index <= '0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_am_move_walker.sv
// tb_am_move_walker: directed vectors against a zero-latency move-RAM model, hand-computed beats and timing.
module tb_am_move_walker;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b0, am_moves_ready = 1'b0;
  logic [7:0] am_move_count = '0;
  logic initial_mate = 1'b0, initial_stalemate = 1'b0;
  logic [15:0] uci_in;
  logic capture_in, white_in_check_in, black_in_check_in;
  logic [7:0] am_move_index;
  logic am_clear_moves, done;
  logic [1:0] term;
  logic [8:0] emitted;
  logic [15:0] mu [256];
  logic mc [256], mw [256], mb [256];
  int checks = 0, failures = 0;
  am_move_walker_if #(.MAX_POSITIONS_LOG2(8), .UCI_WIDTH(16)) s();
  am_move_walker #(.MAX_POSITIONS_LOG2(8), .UCI_WIDTH(16), .RAM_LATENCY(5)) dut (
    .clk(clk), .reset(reset), .enable(enable), .am_moves_ready(am_moves_ready),
    .am_move_count(am_move_count), .initial_mate(initial_mate), .initial_stalemate(initial_stalemate),
    .uci_in(uci_in), .capture_in(capture_in), .white_in_check_in(white_in_check_in),
    .black_in_check_in(black_in_check_in), .am_move_index(am_move_index),
    .am_clear_moves(am_clear_moves), .stream(s), .done(done), .term(term), .emitted(emitted)
  );
  always #5 clk = ~clk;
  assign uci_in = mu[am_move_index];
  assign capture_in = mc[am_move_index];
  assign white_in_check_in = mw[am_move_index];
  assign black_in_check_in = mb[am_move_index];
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set_move(int i, logic c, logic w, logic b);
    mc[i] = c;
    mw[i] = w;
    mb[i] = b;
  endtask
  task automatic arm(int c);
    am_move_count = 8'(c);
    am_moves_ready = 1'b1;
  endtask
  task automatic beat(string tag, int lat, int idx, logic last);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!s.out_valid && n < 100);
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_idx"}, s.out_index, idx);
    chk({tag, "_uci"}, s.out_uci, mu[idx]);
    chk({tag, "_last"}, s.out_last, last);
    chk({tag, "_status"}, s.out_status, mw[idx] ? 1 : mb[idx] ? 2 : 0);
  endtask
  task automatic finish_list(string tag, int em);
    tick();
    chk({tag, "_clear"}, am_clear_moves, 1);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_valid"}, s.out_valid, 0);
    chk({tag, "_emitted"}, emitted, em);
    am_moves_ready = 1'b0;
    tick();
    chk({tag, "_done_pulse"}, done, 0);
    tick();
  endtask
  task automatic reset_checks(string tag);
    chk({tag, "_valid"}, s.out_valid, 0);
    chk({tag, "_index"}, am_move_index, 0);
    chk({tag, "_clear"}, am_clear_moves, 0);
    chk({tag, "_uci"}, s.out_uci, 0);
    chk({tag, "_oidx"}, s.out_index, 0);
    chk({tag, "_status"}, s.out_status, 0);
    chk({tag, "_last"}, s.out_last, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_term"}, term, 0);
    chk({tag, "_emitted"}, emitted, 0);
  endtask
  task automatic empty_list(string tag, logic mate, logic stale, int exp_term);
    initial_mate = mate;
    initial_stalemate = stale;
    arm(0);
    tick();
    chk({tag, "_init_valid"}, s.out_valid, 0);
    finish_list(tag, 0);
    chk({tag, "_term"}, term, exp_term);
    initial_mate = 1'b0;
    initial_stalemate = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < 256; i++) begin
      mu[i] = 16'h1000 + 16'(i * 16'h0141);
      set_move(i, 1'b0, 1'b0, 1'b0);
    end
    s.out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    reset_checks("rst");
    // three moves, consumer always ready; enable dropped mid-walk must not stop it
    set_move(1, 1'b0, 1'b1, 1'b0);
    set_move(2, 1'b0, 1'b0, 1'b1);
    enable = 1'b1;
    s.out_ready = 1'b1;
    arm(3);
    beat("t1b0", 7, 0, 1'b0);
    enable = 1'b0;
    beat("t1b1", 6, 1, 1'b0);
    beat("t1b2", 6, 2, 1'b1);
    finish_list("t1", 3);
    enable = 1'b1;
    // backpressure on the first beat
    set_move(0, 1'b0, 1'b1, 1'b1);
    set_move(1, 1'b0, 1'b0, 1'b1);
    s.out_ready = 1'b0;
    arm(2);
    beat("t2b0", 7, 0, 1'b0);
    repeat (10) tick();
    chk("t2_hold_valid", s.out_valid, 1);
    chk("t2_hold_uci", s.out_uci, mu[0]);
    chk("t2_hold_oidx", s.out_index, 0);
    chk("t2_hold_ramidx", am_move_index, 0);
    chk("t2_hold_emitted", emitted, 0);
    s.out_ready = 1'b1;
    beat("t2b1", 6, 1, 1'b1);
    finish_list("t2", 2);
    empty_list("mate", 1'b1, 1'b0, 1);
    empty_list("stale", 1'b0, 1'b1, 2);
    empty_list("none", 1'b0, 1'b0, 3);
    // four moves with captures at 1 and 3; reset while the first beat is stalled
    for (int i = 0; i < 4; i++) set_move(i, 1'(i % 2), 1'b0, 1'b0);
    mb[1] = 1'b1;
    mw[3] = 1'b1;
    s.out_ready = 1'b0;
    arm(4);
`ifdef AM_WALKER_CAPTURE_FILTER_EN
    beat("t5b0", 12, 1, 1'b0);
`else
    beat("t5b0", 7, 0, 1'b0);
`endif
    reset = 1'b1;
    tick();
    reset_checks("t5rst");
    reset = 1'b0;
    s.out_ready = 1'b1;
`ifdef AM_WALKER_CAPTURE_FILTER_EN
    beat("t6b0", 12, 1, 1'b0);
    beat("t6b1", 11, 3, 1'b1);
    finish_list("t6", 2);
`else
    beat("t6b0", 7, 0, 1'b0);
    beat("t6b1", 6, 1, 1'b0);
    beat("t6b2", 6, 2, 1'b0);
    beat("t6b3", 6, 3, 1'b1);
    finish_list("t6", 4);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
